ident_scanner: RTL and testbench
================================

// Module: ident_scanner
// PURPOSE
//  Parametrised identifier token scanner for a byte-serial character stream.
//  Classifies each accepted char and tracks the current token with an FSM.
//  Reports identifier status, trailing-digit status, token length and a running
//  identifier count; one end-of-token pulse per identifier. Sits after the char
//  source in the lexer path. STRICT mode rejects tokens that start with a digit.
// PARAMETERS
//  CHAR_W      8   char width; classification uses char[7:0], upper bits must be 0 else separator
//  LEN_W       6   token length width; length saturates at 2**LEN_W-1
//  CNT_W       16  identifier counter width; saturates at 2**CNT_W-1
//  ALLOW_USCORE 1  1: '_' (95) counts as a letter; 0: '_' is a separator
//  STRICT      1   1: digit-led run enters NUM, skipped to next separator; 0: digit in IDLE stays IDLE
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous reset, active low
//  in_valid   in   1       char valid this cycle
//  char       in   CHAR_W  input character
//  flush      in   1       end of stream: acts as a separator; in_valid ignored this cycle
//  clear      in   1       synchronous clear of FSM, length, counter, flags
//  in_ident   out  1       state is ALPHA or DIGIT
//  ends_digit out  1       state is DIGIT (last accepted char was a digit inside an identifier)
//  tok_done   out  1       one-cycle pulse: an identifier just terminated
//  tok_len    out  LEN_W   length of terminated identifier; held until next tok_done
//  tok_long   out  1       terminated identifier exceeded 2**LEN_W-1 chars; held with tok_len
//  tok_cnt    out  CNT_W   identifiers terminated since reset/clear
// BEHAVIOUR
//  Classes: L = 'A'-'Z'(65-90), 'a'-'z'(97-122), '_' if ALLOW_USCORE; D = '0'-'9'(48-57); S = other.
//  States: IDLE, ALPHA, DIGIT, NUM. State and all outputs are registered.
//  The FSM advances only on a cycle with in_valid=1 or flush=1; otherwise all state holds.
//  Transitions on an accepted char:
//   IDLE : L->ALPHA (len=1); D->NUM if STRICT else IDLE; S->IDLE
//   ALPHA/DIGIT : L->ALPHA; D->DIGIT (len+1, saturating); S->IDLE + terminate
//   NUM  : L or D->NUM; S->IDLE (no terminate, no count)
//  flush: ALPHA/DIGIT->IDLE + terminate; IDLE/NUM->IDLE, no pulse.
//  Terminate: next edge sets tok_done=1 for exactly one cycle.
//   tok_len is loaded with the final saturated length; tok_long is set if the
//   token ran past saturation.
//   tok_cnt increments by 1 and saturates; it does not wrap.
//  Length: counts every char of the identifier, including its first. At 2**LEN_W-1
//   it holds the value; one more char sets an internal overflow bit, cleared on
//   the next ALPHA entry from IDLE.
//  Latency: in_ident/ends_digit reflect a char one edge after it is accepted;
//   tok_done rises on the same edge as the separator/flush moves the state to IDLE.
//  Priority: rst_n low > clear > flush > in_valid.
//  clear: FSM->IDLE, length/overflow=0, tok_cnt=0, tok_len=0, tok_long=0,
//   tok_done=0; no pulse even if mid-identifier.
//  Reset values: state IDLE, in_ident=0, ends_digit=0, tok_done=0, tok_len=0,
//   tok_long=0, tok_cnt=0. Reset asserted mid-token discards the token; no pulse.
//  Back-to-back separators generate no extra pulses.
//  A separator immediately followed by a letter starts a new token without a gap cycle.
//  With STRICT=0 the FSM matches the legacy letter/digit detector exactly:
//   ends_digit tracks its out, and NUM is never entered.
// TESTING
//  1 "a1b2" then ' ' (in_valid every cycle) -> ends_digit 0,1,0,1,0; tok_done pulse after ' ' with tok_len=4, tok_cnt=1
//  2 STRICT=1: "9ab " -> in_ident stays 0, no tok_done, tok_cnt=0; STRICT=0: same stream -> in_ident=1 after 'a', tok_len=2
//  3 LEN_W=3: "abcdefghij" + flush -> tok_len=7, tok_long=1, tok_done single pulse; next "x " -> tok_len=1, tok_long=0
//  4 "_x" with ALLOW_USCORE=1 -> tok_len=2; with ALLOW_USCORE=0 -> tok_len=1 ('x' only)
//  5 CNT_W=2: five identifiers "a b c d e " -> tok_cnt 1,2,3,3,3 (saturates, no wrap)
//  6 rst_n pulsed low mid "abc" asynchronously -> all outputs 0 immediately, no tok_done; clear+in_valid('a') same cycle -> IDLE, char dropped

Source files
------------

// File: rtl/ident_scanner.sv
// rtl/ident_scanner.sv - identifier token scanner for a byte-serial char stream
module ident_scanner #(
  parameter int CHAR_W       = 8,
  parameter int LEN_W        = 6,
  parameter int CNT_W        = 16,
  parameter int ALLOW_USCORE = 1,
  parameter int STRICT       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CHAR_W-1:0] char,
  input  logic              flush,
  input  logic              clear,
  output logic              in_ident,
  output logic              ends_digit,
  output logic              tok_done,
  output logic [LEN_W-1:0]  tok_len,
  output logic              tok_long,
  output logic [CNT_W-1:0]  tok_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALPHA = 2'd1,
    ST_DIGIT = 2'd2,
    ST_NUM   = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             r_state;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovf;
  logic               r_tok_done;
  logic [LEN_W-1:0]   r_tok_len;
  logic               r_tok_long;
  logic [CNT_W-1:0]   r_tok_cnt;

  state_t             w_state_n;
  logic [LEN_W-1:0]   w_len_n;
  logic               w_ovf_n;
  logic               w_term;
  logic [7:0]         w_lo;
  logic               w_hi_zero;
  logic               w_is_l;
  logic               w_is_d;

  // Any nonzero bit above the low byte makes the char a separator.
  assign w_lo      = char[7:0];
  assign w_hi_zero = ((char >> 8) == '0);
  assign w_is_l    = w_hi_zero &&
                     (((w_lo >= 8'd65) && (w_lo <= 8'd90)) ||
                      ((w_lo >= 8'd97) && (w_lo <= 8'd122)) ||
                      ((ALLOW_USCORE != 0) && (w_lo == 8'd95)));
  assign w_is_d    = w_hi_zero && (w_lo >= 8'd48) && (w_lo <= 8'd57);

  // Next-state, running length and terminate decision for one accepted char or flush.
  always_comb begin
    w_state_n = r_state;
    w_len_n   = r_len;
    w_ovf_n   = r_ovf;
    w_term    = 1'b0;
    if (flush) begin
      w_state_n = ST_IDLE;
      w_term    = (r_state == ST_ALPHA) || (r_state == ST_DIGIT);
    end else if (in_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_l) begin
            w_state_n = ST_ALPHA;
            w_len_n   = {{(LEN_W-1){1'b0}}, 1'b1};
            w_ovf_n   = 1'b0;
          end else if (w_is_d && (STRICT != 0)) begin
            w_state_n = ST_NUM;
          end
        end
        ST_ALPHA, ST_DIGIT: begin
          if (w_is_l || w_is_d) begin
            w_state_n = w_is_l ? ST_ALPHA : ST_DIGIT;
            // Length pins at its maximum; the overflow bit records the run-over.
            if (r_len == LEN_MAX) w_ovf_n = 1'b1;
            else                  w_len_n = r_len + 1'b1;
          end else begin
            w_state_n = ST_IDLE;
            w_term    = 1'b1;
          end
        end
        default: begin
          if (!w_is_l && !w_is_d) w_state_n = ST_IDLE;
        end
      endcase
    end
  end

  // State, length and registered token reporting; clear overrides everything but reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_ovf      <= 1'b0;
      r_tok_done <= 1'b0;
      r_tok_len  <= '0;
      r_tok_long <= 1'b0;
      r_tok_cnt  <= '0;
    end else if (clear) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_ovf      <= 1'b0;
      r_tok_done <= 1'b0;
      r_tok_len  <= '0;
      r_tok_long <= 1'b0;
      r_tok_cnt  <= '0;
    end else begin
      r_state    <= w_state_n;
      r_len      <= w_len_n;
      r_ovf      <= w_ovf_n;
      r_tok_done <= w_term;
      if (w_term) begin
        r_tok_len  <= r_len;
        r_tok_long <= r_ovf;
        if (r_tok_cnt != CNT_MAX) r_tok_cnt <= r_tok_cnt + 1'b1;
      end
    end
  end

  assign in_ident   = (r_state == ST_ALPHA) || (r_state == ST_DIGIT);
  assign ends_digit = (r_state == ST_DIGIT);
  assign tok_done   = r_tok_done;
  assign tok_len    = r_tok_len;
  assign tok_long   = r_tok_long;
  assign tok_cnt    = r_tok_cnt;

endmodule

// File: tb/tb_ident_scanner.sv
// tb/tb_ident_scanner.sv - directed-vector bench for ident_scanner
module tb_ident_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] ch;
  logic       flush;
  logic       clear;

  logic       d_in, d_ends, d_done, d_long;
  logic [5:0] d_len;
  logic [15:0] d_cnt;
  logic       x_in, x_ends, x_done, x_long;
  logic [2:0] x_len;
  logic [1:0] x_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ident_scanner u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .char(ch), .flush(flush), .clear(clear),
    .in_ident(d_in), .ends_digit(d_ends), .tok_done(d_done), .tok_len(d_len),
    .tok_long(d_long), .tok_cnt(d_cnt)
  );

  ident_scanner #(.CHAR_W(8), .LEN_W(3), .CNT_W(2), .ALLOW_USCORE(0), .STRICT(0)) u_x (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .char(ch), .flush(flush), .clear(clear),
    .in_ident(x_in), .ends_digit(x_ends), .tok_done(x_done), .tok_len(x_len),
    .tok_long(x_long), .tok_cnt(x_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] c, input logic fl, input logic cl);
    in_valid = v;
    ch       = c;
    flush    = fl;
    clear    = cl;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    clear    = 1'b0;
  endtask

  initial begin
    string s;
    rst_n = 1'b0; in_valid = 1'b0; ch = 8'd0; flush = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ident", d_in, 0);
    check("rst_ends_digit", d_ends, 0);
    check("rst_tok_done", d_done, 0);
    check("rst_tok_len", d_len, 0);
    check("rst_tok_long", d_long, 0);
    check("rst_tok_cnt", d_cnt, 0);
    rst_n = 1'b1;
    step(0, 8'd0, 0, 0);

    // "a1b2 " : ends_digit 0,1,0,1,0 then pulse with len 4
    step(1, "a", 0, 0); check("t1_ed_a", d_ends, 0); check("t1_in_a", d_in, 1);
    step(1, "1", 0, 0); check("t1_ed_1", d_ends, 1);
    step(1, "b", 0, 0); check("t1_ed_b", d_ends, 0);
    step(1, "2", 0, 0); check("t1_ed_2", d_ends, 1); check("t1_x_ed_2", x_ends, 1);
    step(1, " ", 0, 0);
    check("t1_ed_sp", d_ends, 0); check("t1_done", d_done, 1);
    check("t1_len", d_len, 4); check("t1_cnt", d_cnt, 1);
    check("t1_x_done", x_done, 1); check("t1_x_len", x_len, 4);
    step(0, 8'd0, 0, 0);
    check("t1_done_drop", d_done, 0); check("t1_len_hold", d_len, 4);

    // "9ab " : strict skips, lax sees "ab"
    step(1, "9", 0, 0); check("t2_in_9", d_in, 0); check("t2_x_in_9", x_in, 0);
    step(1, "a", 0, 0); check("t2_in_a", d_in, 0); check("t2_x_in_a", x_in, 1);
    step(1, "b", 0, 0); check("t2_in_b", d_in, 0);
    step(1, " ", 0, 0);
    check("t2_done", d_done, 0); check("t2_cnt", d_cnt, 1);
    check("t2_x_done", x_done, 1); check("t2_x_len", x_len, 2); check("t2_x_cnt", x_cnt, 2);

    // ten letters then flush (with in_valid asserted, which must be ignored)
    s = "abcdefghij";
    for (int i = 0; i < s.len(); i++) step(1, s[i], 0, 0);
    step(1, "q", 1, 0);
    check("t3_done", d_done, 1); check("t3_len", d_len, 10); check("t3_long", d_long, 0);
    check("t3_in_after_flush", d_in, 0);
    check("t3_x_done", x_done, 1); check("t3_x_len", x_len, 7); check("t3_x_long", x_long, 1);
    check("t3_x_cnt", x_cnt, 3);
    step(0, 8'd0, 0, 0);
    check("t3_x_single_pulse", x_done, 0); check("t3_x_long_hold", x_long, 1);
    step(1, "x", 0, 0);
    step(1, " ", 0, 0);
    check("t3_x_len2", x_len, 1); check("t3_x_long2", x_long, 0); check("t3_x_cnt_sat", x_cnt, 3);
    check("t3_cnt", d_cnt, 3);

    // underscore handling
    step(1, "_", 0, 0); check("t4_in_us", d_in, 1); check("t4_x_in_us", x_in, 0);
    step(1, "x", 0, 0);
    step(1, " ", 0, 0);
    check("t4_len", d_len, 2); check("t4_x_len", x_len, 1); check("t4_x_done", x_done, 1);

    // class boundaries: '@' '[' '{' are separators, 'Z' 'z' '0' are not
    step(1, "@", 0, 0); check("tb_in_at", d_in, 0);
    step(1, "Z", 0, 0); check("tb_in_Z", d_in, 1);
    step(1, "0", 0, 0); check("tb_ed_0", d_ends, 1);
    step(1, "[", 0, 0); check("tb_done_br", d_done, 1); check("tb_len_br", d_len, 2);
    step(1, "z", 0, 0); check("tb_in_z", d_in, 1); check("tb_done_z", d_done, 0);
    step(1, "{", 0, 0); check("tb_len_cb", d_len, 1); check("tb_cnt", d_cnt, 6);

    // clear mid-identifier with a simultaneous letter
    step(1, "a", 0, 0);
    step(1, "b", 0, 0);
    step(1, "a", 0, 1);
    check("t6_clr_in", d_in, 0); check("t6_clr_done", d_done, 0);
    check("t6_clr_cnt", d_cnt, 0); check("t6_clr_len", d_len, 0); check("t6_clr_x_cnt", x_cnt, 0);
    step(1, " ", 0, 0);
    check("t6_clr_no_pulse", d_done, 0);

    // counter saturation with CNT_W=2
    for (int i = 0; i < 5; i++) begin
      step(1, 8'(8'd97 + i), 0, 0);
      step(1, " ", 0, 0);
      check("t5_cnt", d_cnt, i + 1);
      check("t5_x_cnt", x_cnt, (i < 3) ? i + 1 : 3);
    end
    step(1, " ", 0, 0);
    check("t5_b2b_done", d_done, 0); check("t5_b2b_x_done", x_done, 0); check("t5_b2b_cnt", d_cnt, 5);

    // asynchronous reset mid-token
    step(1, "a", 0, 0);
    step(1, "b", 0, 0);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_in", d_in, 0); check("t6_rst_len", d_len, 0); check("t6_rst_cnt", d_cnt, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(0, 8'd0, 0, 0);
    check("t6_rst_no_pulse", d_done, 0);
    step(1, "c", 0, 0);
    step(1, " ", 0, 0);
    check("t6_new_len", d_len, 1); check("t6_new_cnt", d_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
